// File: rtl/mem_bus_arb_if.sv
// mem_bus_arb_if: one CPU-memory-bus link (command + read response).
//
// Signals:
//   cmd_valid / cmd_ready   command handshake
//   cmd_wr                  1 = write, 0 = read
//   cmd_addr[31:0]          byte address
//   cmd_wdata[31:0]         write data
//   cmd_be[3:0]             byte enables
//   rsp_ready               single-cycle read-data-valid pulse
//   rsp_rdata[31:0]         read data
//
// Modports:
//   master  the side that issues commands and receives responses
//   slave   the side that accepts commands and returns responses
interface mem_bus_arb_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_be,
    input  cmd_ready, rsp_ready, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_be,
    output cmd_ready, rsp_ready, rsp_rdata
  );
endinterface

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-master / one-slave arbiter for the CPU memory bus.
//
// Commands from m0 (CPU) and m1 (DMA/debug) are multiplexed onto s with no
// added latency. Grants alternate round-robin under contention; accepted
// reads record their master ID in a FIFO so that in-order slave responses
// are steered back to the right master combinationally.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   m0, m1        master links (slave modport: arbiter accepts commands)
//   s             link to the address decoder (master modport)
//   busy          one or more reads outstanding
//   protocol_err  sticky: slave response seen with no read outstanding
//
// Parameters:
//   MAX_OUTSTANDING  read-ID FIFO depth (power of 2, 2..16)
//
// Build option:
//   MEM_BUS_ARB_FIXED_PRIO_EN  when defined, m0 has strict priority over m1
//                              and no round-robin state is kept.
module mem_bus_arb #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_bus_arb_if.slave  m0,
  mem_bus_arb_if.slave  m1,
  mem_bus_arb_if.master s,
  output logic          busy,
  output logic          protocol_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        id_mem [MAX_OUTSTANDING];

  logic        fifo_empty;
  logic        fifo_full;
  logic        elig0;
  logic        elig1;
  logic        sel0;
  logic        sel1;
  logic        accept;
  logic        push;
  logic        pop;
  logic        head_id;

  logic        mux_wr;
  logic [31:0] mux_addr;
  logic [31:0] mux_wdata;
  logic [3:0]  mux_be;

`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
  logic        last_grant;
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Reads stall on a full FIFO; writes never do. Fullness is purely
  // registered state, so a same-cycle response cannot open a read slot
  // (keeps rsp_ready out of the cmd_ready path).
  assign elig0 = !reset && m0.cmd_valid && (m0.cmd_wr || !fifo_full);
  assign elig1 = !reset && m1.cmd_valid && (m1.cmd_wr || !fifo_full);

`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
  assign sel1 = elig1 && !elig0;
`else
  // Under contention the master that did not win last time is chosen.
  assign sel1 = elig1 && (!elig0 || !last_grant);
`endif
  assign sel0 = elig0 && !sel1;

  // Fields follow m0 whenever m1 is not selected, including the idle case.
  always_comb begin
    mux_wr    = m0.cmd_wr;
    mux_addr  = m0.cmd_addr;
    mux_wdata = m0.cmd_wdata;
    mux_be    = m0.cmd_be;
    if (sel1) begin
      mux_wr    = m1.cmd_wr;
      mux_addr  = m1.cmd_addr;
      mux_wdata = m1.cmd_wdata;
      mux_be    = m1.cmd_be;
    end
  end

  assign s.cmd_valid = elig0 || elig1;
  assign s.cmd_wr    = mux_wr;
  assign s.cmd_addr  = mux_addr;
  assign s.cmd_wdata = mux_wdata;
  assign s.cmd_be    = mux_be;

  assign m0.cmd_ready = sel0 && s.cmd_ready;
  assign m1.cmd_ready = sel1 && s.cmd_ready;

  assign accept = (elig0 || elig1) && s.cmd_ready;
  assign push   = accept && !mux_wr;
  assign pop    = !reset && s.rsp_ready && !fifo_empty;

  // Response routing: head of the ID FIFO names the owner of this response.
  assign head_id      = id_mem[rd_ptr[PW-1:0]];
  assign m0.rsp_ready = pop && !head_id;
  assign m1.rsp_ready = pop && head_id;
  assign m0.rsp_rdata = (pop && !head_id) ? s.rsp_rdata : 32'h0;
  assign m1.rsp_rdata = (pop && head_id)  ? s.rsp_rdata : 32'h0;

  assign busy = !fifo_empty;

  // Control state: pointers, sticky error, round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      protocol_err <= 1'b0;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (s.rsp_ready && fifo_empty)
        protocol_err <= 1'b1;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
      if (accept)
        last_grant <= sel1;
`endif
    end
  end

  // ID storage: data only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push)
      id_mem[wr_ptr[PW-1:0]] <= sel1;
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed bench for mem_bus_arb (MAX_OUTSTANDING = 4).
// Covers reset outputs, write arbitration, response routing, FIFO-full
// stalling, push/pop at constant occupancy with pointer wraps, the
// protocol-error flag and reset with reads in flight.
module tb_mem_bus_arb;

  logic clk;
  logic reset;
  logic busy;
  logic protocol_err;

  int n_checks;
  int n_pass;

  mem_bus_arb_if m0_if ();
  mem_bus_arb_if m1_if ();
  mem_bus_arb_if s_if ();

  mem_bus_arb #(.MAX_OUTSTANDING(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0           (m0_if),
    .m1           (m1_if),
    .s            (s_if),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_if.cmd_valid = 1'b0;
    m1_if.cmd_valid = 1'b0;
    s_if.rsp_ready  = 1'b0;
    s_if.rsp_rdata  = 32'h0;
  endtask

  task automatic set_read(input logic m, input logic [31:0] addr);
    m0_if.cmd_valid = !m;
    m1_if.cmd_valid = m;
    m0_if.cmd_wr    = 1'b0;
    m1_if.cmd_wr    = 1'b0;
    if (m) m1_if.cmd_addr = addr;
    else   m0_if.cmd_addr = addr;
  endtask

  function automatic logic rdy_of(input logic m);
    return m ? m1_if.cmd_ready : m0_if.cmd_ready;
  endfunction

  logic [21:0] seq;
  logic [31:0] exp_addr;
  logic [1:0]  exp_rdy;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    seq      = 22'b10_1100_1011_1000_1101_0011;

    // Reset: drive activity to prove outputs stay quiet.
    reset = 1'b1;
    m0_if.cmd_valid = 1'b1; m0_if.cmd_wr = 1'b1; m0_if.cmd_addr = 32'h10;
    m0_if.cmd_wdata = 32'h0; m0_if.cmd_be = 4'hF;
    m1_if.cmd_valid = 1'b0; m1_if.cmd_wr = 1'b1; m1_if.cmd_addr = 32'hF000_0004;
    m1_if.cmd_wdata = 32'h0; m1_if.cmd_be = 4'hF;
    s_if.cmd_ready = 1'b1; s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'h1234;
    tick();
    tick();
    chk("rst_s_valid", {31'h0, s_if.cmd_valid}, 32'h0);
    chk("rst_m0_rdy", {31'h0, m0_if.cmd_ready}, 32'h0);
    chk("rst_m0_rsp", {31'h0, m0_if.rsp_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_perr", {31'h0, protocol_err}, 32'h0);
    idle();
    reset = 1'b0;
    tick();

    // Back-to-back writes from both masters.
    m0_if.cmd_valid = 1'b1; m0_if.cmd_wr = 1'b1; m0_if.cmd_addr = 32'h0000_0010;
    m1_if.cmd_valid = 1'b1; m1_if.cmd_wr = 1'b1; m1_if.cmd_addr = 32'hF000_0004;
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
      exp_addr = 32'h0000_0010;
      exp_rdy  = 2'b01;
`else
      exp_addr = (c % 2 == 0) ? 32'h0000_0010 : 32'hF000_0004;
      exp_rdy  = (c % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("wr_addr", s_if.cmd_addr, exp_addr);
      chk("wr_rdy", {30'h0, m1_if.cmd_ready, m0_if.cmd_ready}, {30'h0, exp_rdy});
      tick();
    end
    idle();
    chk("wr_nobusy", {31'h0, busy}, 32'h0);

    // Read routing: m0 reads 0x100, then m1 reads 0x200.
    set_read(1'b0, 32'h100);
    #1;
    chk("rd0_rdy", {31'h0, m0_if.cmd_ready}, 32'h1);
    tick();
    set_read(1'b1, 32'h200);
    #1;
    chk("rd1_rdy", {31'h0, m1_if.cmd_ready}, 32'h1);
    chk("rd1_addr", s_if.cmd_addr, 32'h200);
    tick();
    idle();
    #1;
    chk("rd_busy", {31'h0, busy}, 32'h1);
    s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'hAAAA_0001;
    #1;
    chk("rsp0_rdy", {30'h0, m1_if.rsp_ready, m0_if.rsp_ready}, 32'h1);
    chk("rsp0_data", m0_if.rsp_rdata, 32'hAAAA_0001);
    chk("rsp0_m1data", m1_if.rsp_rdata, 32'h0);
    tick();
    idle();
    tick();
    s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'hBBBB_0002;
    #1;
    chk("rsp1_rdy", {30'h0, m1_if.rsp_ready, m0_if.rsp_ready}, 32'h2);
    chk("rsp1_data", m1_if.rsp_rdata, 32'hBBBB_0002);
    chk("rsp1_m0data", m0_if.rsp_rdata, 32'h0);
    tick();
    idle();
    #1;
    chk("rsp_idle", {31'h0, busy}, 32'h0);

    // Fill the FIFO with four m0 reads.
    for (int i = 0; i < 4; i++) begin
      set_read(1'b0, 32'h300 + 32'(4 * i));
      #1;
      chk("fill_rdy", {31'h0, m0_if.cmd_ready}, 32'h1);
      tick();
    end
    set_read(1'b0, 32'h310);
    m1_if.cmd_valid = 1'b1; m1_if.cmd_wr = 1'b1; m1_if.cmd_addr = 32'hF000_0004;
    #1;
    chk("full_m0_stall", {31'h0, m0_if.cmd_ready}, 32'h0);
    chk("full_m1_wr", {31'h0, m1_if.cmd_ready}, 32'h1);
    chk("full_addr", s_if.cmd_addr, 32'hF000_0004);
    chk("full_busy", {31'h0, busy}, 32'h1);
    tick();
    m1_if.cmd_valid = 1'b0;
    s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'h5555_0000;
    #1;
    chk("full_pop_stall", {31'h0, m0_if.cmd_ready}, 32'h0);
    chk("full_pop_rsp", {31'h0, m0_if.rsp_ready}, 32'h1);
    tick();
    s_if.rsp_ready = 1'b0;
    #1;
    chk("full_5th_acc", {31'h0, m0_if.cmd_ready}, 32'h1);
    chk("full_5th_addr", s_if.cmd_addr, 32'h310);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'h6000 + 32'(i);
      #1;
      chk("drain_rsp", {30'h0, m1_if.rsp_ready, m0_if.rsp_ready}, 32'h1);
      tick();
    end
    idle();
    #1;
    chk("drain_busy", {31'h0, busy}, 32'h0);

    // Occupancy held at 2 with push and pop in the same cycle.
    for (int k = 0; k < 2; k++) begin
      set_read(seq[k], 32'h400 + 32'(4 * k));
      #1;
      chk("pp_pre_rdy", {31'h0, rdy_of(seq[k])}, 32'h1);
      tick();
    end
    for (int j = 0; j < 20; j++) begin
      set_read(seq[j+2], 32'h400 + 32'(4 * (j + 2)));
      s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'hC000_0000 + 32'(j);
      #1;
      chk("pp_cmd_rdy", {31'h0, rdy_of(seq[j+2])}, 32'h1);
      chk("pp_rsp_route", {30'h0, m1_if.rsp_ready, m0_if.rsp_ready},
          seq[j] ? 32'h2 : 32'h1);
      chk("pp_rdata", seq[j] ? m1_if.rsp_rdata : m0_if.rsp_rdata,
          32'hC000_0000 + 32'(j));
      chk("pp_busy", {31'h0, busy}, 32'h1);
      tick();
    end
    idle();
    for (int j = 20; j < 22; j++) begin
      s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'hD000_0000 + 32'(j);
      #1;
      chk("pp_drain_route", {30'h0, m1_if.rsp_ready, m0_if.rsp_ready},
          seq[j] ? 32'h2 : 32'h1);
      tick();
    end
    idle();
    #1;
    chk("pp_empty", {31'h0, busy}, 32'h0);
    chk("pp_no_perr", {31'h0, protocol_err}, 32'h0);

    // Response with nothing outstanding.
    s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'hDEAD_BEEF;
    #1;
    chk("orphan_rsp", {30'h0, m1_if.rsp_ready, m0_if.rsp_ready}, 32'h0);
    chk("orphan_data", m0_if.rsp_rdata | m1_if.rsp_rdata, 32'h0);
    tick();
    idle();
    #1;
    chk("perr_set", {31'h0, protocol_err}, 32'h1);
    tick();
    tick();
    chk("perr_sticky", {31'h0, protocol_err}, 32'h1);

    // Reset with three reads in flight; last acceptance is m0.
    set_read(1'b1, 32'h500); tick();
    set_read(1'b1, 32'h504); tick();
    set_read(1'b0, 32'h508);
    #1;
    chk("mid_rdy", {31'h0, m0_if.cmd_ready}, 32'h1);
    tick();
    idle();
    #1;
    chk("mid_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_perr", {31'h0, protocol_err}, 32'h0);
    m0_if.cmd_valid = 1'b1; m0_if.cmd_wr = 1'b1; m0_if.cmd_addr = 32'h0000_0010;
    m1_if.cmd_valid = 1'b1; m1_if.cmd_wr = 1'b1; m1_if.cmd_addr = 32'hF000_0004;
    #1;
    chk("post_rst_addr", s_if.cmd_addr, 32'h0000_0010);
    chk("post_rst_rdy", {30'h0, m1_if.cmd_ready, m0_if.cmd_ready}, 32'h1);
    tick();
    idle();
    s_if.rsp_ready = 1'b1; s_if.rsp_rdata = 32'h7777_0000;
    #1;
    chk("late_rsp", {30'h0, m1_if.rsp_ready, m0_if.rsp_ready}, 32'h0);
    tick();
    idle();
    #1;
    chk("late_perr", {31'h0, protocol_err}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arb.md
Name: mem_bus_arb

Overview:
- Two-master, one-slave arbiter on the SoC CPU memory bus (cmd valid/ready plus rsp_ready/rdata protocol).
- Lets a second master (DMA or debug engine) share the decoded slave fabric (local RAM, GPIO, SBUF) with the CPU.
- Round-robin grant on commands; in-order read-response routing through an ID FIFO of outstanding reads.
- Sits between the CPU wrapper and the address decoder.

Parameters:
- MAX_OUTSTANDING, 4, depth of the read-ID FIFO (power of 2, 2..16); max reads in flight across both masters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_cmd_valid / m1_cmd_valid  in  1  master command request
- m0_cmd_ready / m1_cmd_ready  out  1  command accepted this cycle
- m0_cmd_wr / m1_cmd_wr  in  1  1=write, 0=read
- m0_cmd_addr / m1_cmd_addr  in  32  byte address
- m0_cmd_wdata / m1_cmd_wdata  in  32  write data
- m0_cmd_be / m1_cmd_be  in  4  byte enables
- m0_rsp_ready / m1_rsp_ready  out  1  read data valid pulse to that master
- m0_rsp_rdata / m1_rsp_rdata  out  32  read data; 0 when that master's rsp_ready=0
- s_cmd_valid  out  1  to decoder
- s_cmd_ready  in  1  from decoder
- s_cmd_wr, s_cmd_addr[31:0], s_cmd_wdata[31:0], s_cmd_be[3:0]  out  muxed command fields
- s_rsp_ready  in  1  slave read response pulse
- s_rsp_rdata  in  32  slave read data
- busy  out  1  one or more reads outstanding
- protocol_err  out  1  sticky: response arrived with no read outstanding

Behaviour:
- Reset is synchronous and active-high on clk. Reset clears:
  - ID FIFO (empty), protocol_err=0, busy=0.
  - last_grant=1, so m0 wins the first contention.
  - Outputs during reset: all cmd_ready=0, s_cmd_valid=0, all rsp_ready=0.
- Grant selection (combinational each cycle):
  - Eligible: mX_cmd_valid && (mX_cmd_wr || !fifo_full).
  - Only one master eligible: it is selected.
  - Both eligible: the master != last_grant is selected.
  - s_cmd_* = selected master's fields; s_cmd_valid=1 if any master is eligible.
  - When nothing is selected, s_cmd_* fields are driven from m0.
- Acceptance:
  - mX_cmd_ready = selected(X) && s_cmd_ready; 0 for the unselected master.
  - last_grant updates only on acceptance (s_cmd_valid && s_cmd_ready).
  - No registered stage: zero added command latency.
- Read tracking:
  - An accepted read pushes its master ID into the FIFO; writes push nothing.
  - fifo_full blocks read eligibility only. Writes are never blocked by the FIFO.
  - A push at full is never allowed, even with a same-cycle pop; no rsp-to-cmd_ready combinational path.
- Response routing:
  - On s_rsp_ready with the FIFO non-empty: pop the head ID; that master gets rsp_ready=1 and rdata=s_rsp_rdata the same cycle (combinational, 0 added latency).
  - The other master gets rsp_ready=0, rdata=0.
- Simultaneous push and pop (FIFO not full): both happen; occupancy unchanged.
- Response with the FIFO empty: dropped (no master rsp_ready), protocol_err<=1 until reset.
- busy = FIFO occupancy != 0.
- Wrap-around: FIFO pointers are log2(MAX_OUTSTANDING)+1 bits; full/empty come from MSB compare.
- Reset mid-operation: in-flight reads are forgotten. Late slave responses after reset set protocol_err.
- Master stability: a master must hold cmd fields stable while valid && !ready. The arbiter may switch grant between cycles only when nothing was accepted and the preferred master changes eligibility.

Optional Feature:
- Macro: MEM_BUS_ARB_FIXED_PRIO_EN.
- Defined: m0 (CPU) has strict priority. m1 is selected only when m0 is not eligible. last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Both masters issue back-to-back writes (m0 addr 0x0000_0010, m1 addr 0xF000_0004), s_cmd_ready=1 -> accepts alternate m0,m1,m0,m1 starting with m0. The fixed-prio build accepts only m0 while it is valid.
- m0 reads 0x100, then m1 reads 0x200; slave answers 0xAAAA_0001 then 0xBBBB_0002 two cycles apart -> m0_rsp_ready with 0xAAAA_0001, then m1_rsp_ready with 0xBBBB_0002. The other master's rsp_ready=0, rdata=0.
- MAX_OUTSTANDING=4: issue 4 reads with no responses -> the 5th read is stalled (cmd_ready=0) and busy=1. A concurrent m1 write is still accepted. After one s_rsp_ready pulse, the 5th read is accepted the next cycle.
- A same-cycle read acceptance and s_rsp_ready at occupancy 2 -> occupancy stays 2; IDs stay in order over 20 random reads, including 2 full pointer wraps.
- s_rsp_ready pulse with no reads outstanding -> no master rsp_ready; protocol_err=1 and stays 1 until reset.
- Assert reset for 1 cycle with 3 reads outstanding -> busy=0 and FIFO empty. The next contended command is granted to m0. A late response sets protocol_err.
